// File: rtl/addsub_pkg.sv
// Shared types and helpers for the bit-serial demux adder/subtractor.
// Holds the controller state encoding, mode constants and the overflow rule.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Signed overflow from operand and result sign bits only.
  function automatic logic signed_ovf(input logic mode, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic same_sign;
    same_sign = (a_msb == b_msb);
    if (mode == MODE_ADD) return same_sign && (r_msb != a_msb);
    else                  return !same_sign && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_addsub_demux_if.sv
// Request/response bundle between a requester and the serial adder/subtractor.
// Handshake: start is taken on a rising edge only while busy=0; done pulses one cycle with result/cout/ovf valid.
interface serial_addsub_demux_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, cin, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, mode, cin, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/fas_cell_demux.sv
// One-bit full adder / full subtractor built from a 1x8 demux decode of {x, y, c}.
// Sum and difference share the same minterms; only the carry/borrow term depends on mode.
module fas_cell_demux
  import addsub_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  input  logic mode,
  output logic sum_bit,
  output logic carry_next
);

  logic [2:0] sel;
  logic [7:0] dec;

  always_comb begin
    sel = {x_i, y_i, c_i};
    dec = 8'd1 << sel;
    sum_bit = dec[1] | dec[2] | dec[4] | dec[7];
    if (mode == MODE_ADD) carry_next = dec[3] | dec[5] | dec[6] | dec[7];
    else                  carry_next = dec[1] | dec[2] | dec[3] | dec[7];
  end

endmodule

// File: rtl/serial_addsub_demux.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// A single demux cell is reused every RUN cycle; the carry/borrow chain lives in carry_q.
module serial_addsub_demux
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_demux_if.slave bus,
  output state_t               state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             cell_bit;
  logic             cell_carry;
  logic [WIDTH-1:0] res_next;

  fas_cell_demux u_cell (
    .x_i       (a_sh_q[0]),
    .y_i       (b_sh_q[0]),
    .c_i       (carry_q),
    .mode      (mode_q),
    .sum_bit   (cell_bit),
    .carry_next(cell_carry)
  );

  assign accept = bus.start && (state_q != RUN);
  // The final bit comes straight from the cell, so only WIDTH-1 bits need staging.
  assign res_next = {cell_bit, res_sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next[WIDTH-1:1];
        carry_d  = cell_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = res_next;
          cout_d   = cell_carry;
          ovf_d    = signed_ovf(mode_q, a_msb_q, b_msb_q, cell_bit);
        end
      end
      default: state_d = accept ? RUN : IDLE;
    endcase

    // DONE also accepts, giving back-to-back operation with no IDLE gap.
    if (accept) begin
      a_sh_d   = bus.a;
      b_sh_d   = bus.b;
      res_sh_d = '0;
      carry_d  = bus.cin;
      mode_d   = bus.mode;
      a_msb_d  = bus.a[WIDTH-1];
      b_msb_d  = bus.b[WIDTH-1];
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      mode_q   <= MODE_ADD;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_addsub_demux.sv
// Bench for serial_addsub_demux: directed WIDTH=8 cases plus randomized WIDTH=16 ops
// checked against an arithmetic reference model.
module tb_serial_addsub_demux;
  import addsub_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state8, state16;
  int     vectors;
  int     miscompares;

  serial_addsub_demux_if #(.WIDTH(8))  bus8 ();
  serial_addsub_demux_if #(.WIDTH(16)) bus16 ();

  serial_addsub_demux #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus8),
    .state_dbg(state8)
  );

  serial_addsub_demux #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus16),
    .state_dbg(state16)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic; borrow is a < b + cin; ovf from sign bits.
  task automatic ref_model(input int w, input logic md, input logic ci,
                           input logic [63:0] av, input logic [63:0] bv,
                           output logic [63:0] r, output logic co, output logic ov);
    logic [63:0] mask, s;
    logic        am, bm, rm;
    mask = (64'd1 << w) - 64'd1;
    if (md == MODE_ADD) begin
      s  = av + bv + 64'(ci);
      r  = s & mask;
      co = s[w];
    end else begin
      co = (av < bv + 64'(ci));
      r  = (av - bv - 64'(ci)) & mask;
    end
    am = av[w-1];
    bm = bv[w-1];
    rm = r[w-1];
    if (md == MODE_ADD) ov = (am == bm) && (rm != am);
    else                ov = (am != bm) && (rm != am);
  endtask

  // ---------------- drivers (caller is at a negedge) ----------------
  task automatic start_op8(input logic md, input logic ci, input logic [7:0] av, input logic [7:0] bv);
    bus8.start = 1'b1;
    bus8.mode  = md;
    bus8.cin   = ci;
    bus8.a     = av;
    bus8.b     = bv;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.mode  = ~md;
    bus8.cin   = ~ci;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
  endtask

  task automatic wait_done8(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus8.busy) bcnt++;
      if (bus8.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic start_op16(input logic md, input logic ci, input logic [15:0] av, input logic [15:0] bv);
    bus16.start = 1'b1;
    bus16.mode  = md;
    bus16.cin   = ci;
    bus16.a     = av;
    bus16.b     = bv;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    bus16.cin   = 1'($urandom);
    bus16.mode  = 1'($urandom);
  endtask

  task automatic wait_done16(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus16.busy) bcnt++;
      if (bus16.done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full directed op on the 8-bit instance with explicit expectations.
  task automatic op8(input string tag, input logic md, input logic ci,
                     input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] er, input logic eco, input logic eov);
    int lat, bcnt;
    @(negedge clk);
    start_op8(md, ci, av, bv);
    wait_done8(lat, bcnt);
    check({tag, " latency"}, 64'(lat), 64'd9);
    check({tag, " busy_cycles"}, 64'(bcnt), 64'd8);
    check({tag, " result"}, 64'(bus8.result), 64'(er));
    check({tag, " cout"}, 64'(bus8.cout), 64'(eco));
    check({tag, " ovf"}, 64'(bus8.ovf), 64'(eov));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(bus8.done), 64'd0);
    check({tag, " result_hold"}, 64'(bus8.result), 64'(er));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, bcnt, done_seen;
    logic [63:0] er;
    logic        eco, eov;
    logic        md, ci;
    logic [15:0] av, bv;

    vectors     = 0;
    miscompares = 0;
    bus8.start  = 1'b0;
    bus8.mode   = MODE_ADD;
    bus8.cin    = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus16.start = 1'b0;
    bus16.mode  = MODE_ADD;
    bus16.cin   = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    check("reset busy", 64'(bus8.busy), 64'd0);
    check("reset done", 64'(bus8.done), 64'd0);
    check("reset result", 64'(bus8.result), 64'd0);
    check("reset cout", 64'(bus8.cout), 64'd0);
    check("reset ovf", 64'(bus8.ovf), 64'd0);
    check("reset state", 64'(state8), 64'(IDLE));
    check("reset result16", 64'(bus16.result), 64'd0);
    rst_n = 1'b1;

    op8("add_3c_21", MODE_ADD, 1'b0, 8'h3C, 8'h21, 8'h5D, 1'b0, 1'b0);
    op8("add_7f_01", MODE_ADD, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    op8("add_ff_00_c", MODE_ADD, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    op8("sub_10_20", MODE_SUB, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    op8("sub_80_01", MODE_SUB, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8("sub_05_05_b", MODE_SUB, 1'b1, 8'h05, 8'h05, 8'hFF, 1'b1, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    start_op8(MODE_ADD, 1'b0, 8'h3C, 8'h21);
    repeat (4) @(negedge clk);
    start_op8(MODE_SUB, 1'b1, 8'hAA, 8'h55);
    wait_done8(lat, bcnt);
    check("ignore latency", 64'(lat), 64'd5);
    check("ignore result", 64'(bus8.result), 64'h5D);
    check("ignore cout", 64'(bus8.cout), 64'd0);
    @(negedge clk);
    check("ignore no_second_op", 64'(bus8.busy), 64'd0);

    // back-to-back accept in the DONE cycle
    start_op8(MODE_ADD, 1'b0, 8'h7F, 8'h01);
    wait_done8(lat, bcnt);
    check("b2b first latency", 64'(lat), 64'd9);
    check("b2b first result", 64'(bus8.result), 64'h80);
    start_op8(MODE_SUB, 1'b0, 8'h10, 8'h20);
    wait_done8(lat, bcnt);
    check("b2b second latency", 64'(lat), 64'd9);
    check("b2b second busy", 64'(bcnt), 64'd8);
    check("b2b second result", 64'(bus8.result), 64'hF0);
    check("b2b second cout", 64'(bus8.cout), 64'd1);

    // reset during the 5th RUN cycle
    @(negedge clk);
    start_op8(MODE_ADD, 1'b0, 8'h3C, 8'h21);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus8.busy), 64'd0);
    check("abort done", 64'(bus8.done), 64'd0);
    check("abort result", 64'(bus8.result), 64'd0);
    check("abort cout", 64'(bus8.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) done_seen++;
    end
    check("abort no_done", 64'(done_seen), 64'd0);
    op8("post_reset", MODE_SUB, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // randomized 16-bit ops against the reference model
    for (int n = 0; n < 1000; n++) begin
      md = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      av = 16'($urandom_range(0, 16'hFFFF));
      bv = 16'($urandom_range(0, 16'hFFFF));
      if (n % 10 == 0) av = 16'h8000 | av[3:0];
      ref_model(16, md, ci, 64'(av), 64'(bv), er, eco, eov);
      @(negedge clk);
      start_op16(md, ci, av, bv);
      wait_done16(lat, bcnt);
      check("rnd16 latency", 64'(lat), 64'd17);
      check("rnd16 busy", 64'(bcnt), 64'd16);
      check("rnd16 result", 64'(bus16.result), er);
      check("rnd16 cout", 64'(bus16.cout), 64'(eco));
      check("rnd16 ovf", 64'(bus16.ovf), 64'(eov));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_addsub_demux.md
Name: serial_addsub_demux

Overview:
- Parametrised bit-serial WIDTH-bit adder/subtractor. Processes one bit per clock, LSB first.
- Each bit is computed by a 1-bit full-adder/full-subtractor cell whose minterms come from a 1x8 demux decode of {a_i, b_i, carry/borrow}.
- Provides start/busy/done handshake, runtime add/sub mode, carry/borrow-in, and carry/borrow-out and signed-overflow flags.
- Sits in the arithmetic library as the sequential, area-minimal successor of the single-bit demux adder/subtractor cells.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin)
cin  input  1  carry-in (add) or borrow-in (sub)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  sum or difference
cout  output  1  carry-out (add) or borrow-out (sub)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, cout, ovf = 0; result = 0; counter, shift registers and carry flop = 0.
- rst_n low mid-operation aborts immediately to these values. No partial result is kept and no done is issued.

State machine (IDLE, RUN, DONE):
- IDLE: start=1 accepts the request on edge E0. a, b and mode are latched, carry flop <= cin, cnt <= 0, next state RUN.
- RUN: each edge feeds cell inputs {a_sh[0], b_sh[0], carry} through the demux cell. The cell bit shifts into the MSB of the result shift register, the carry flop is updated, a_sh/b_sh shift right, and cnt increments.
- RUN exit: on the edge where cnt==WIDTH-1, go to DONE and register result, cout and ovf.
- DONE: lasts exactly one cycle with done=1. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accept, new operands latched).
- Handshake: start is accepted only when busy=0 (IDLE or DONE). start while busy is ignored with no queuing. Inputs a, b, mode and cin may change freely after acceptance.

Latency and hold:
- busy is high for exactly WIDTH cycles following E0.
- done is asserted in cycle WIDTH+1 after E0.
- result, cout and ovf hold their values until the next completion or reset.

Cell equations (via 1x8 decode of sel={x,y,c}, outputs y0..y7):
- Add: s = y1|y2|y4|y7; c' = y3|y5|y6|y7.
- Sub: d = y1|y2|y4|y7; borrow' = y1|y2|y3|y7.

Flags:
- cout = final carry flop, i.e. carry or borrow out of the MSB.
- ovf, add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
- ovf, sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
- Flags use the latched operands, not live inputs.

Arithmetic: modulo 2^WIDTH. Subtraction is true borrow-chain subtraction, not two's-complement add, so cout means borrow in sub mode.

Decomposition:
- Package addsub_pkg: state enum (IDLE, RUN, DONE), MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module fas_cell_demux: combinational 1x8 demux decode plus mode-selected OR of minterms, giving outputs bit and carry_next. Instantiated once and reused every cycle.

Test Plan:
- WIDTH=8, add, a=8'h3C, b=8'h21, cin=0 -> done 9 cycles after accept; result=8'h5D, cout=0, ovf=0; busy high exactly 8 cycles.
- Add, a=8'h7F, b=8'h01, cin=0 -> result=8'h80, cout=0, ovf=1. Add, a=8'hFF, b=8'h00, cin=1 -> result=8'h00, cout=1, ovf=0.
- Sub, a=8'h10, b=8'h20, cin=0 -> result=8'hF0, cout=1, ovf=0. Sub, a=8'h80, b=8'h01, cin=0 -> result=8'h7F, cout=0, ovf=1.
- start pulsed in the 4th busy cycle with different operands -> ignored; the original result completes unchanged. start held high in the DONE cycle -> second op begins with no IDLE gap, done again 9 cycles later.
- rst_n asserted during the 5th RUN cycle -> all outputs 0 immediately, no done pulse. A new op after release yields the correct result.
- WIDTH=16 instance: randomized 1000 ops, both modes and random cin -> result/cout/ovf match a reference model, done latency is always 17.
